// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: round-robin arbiter that time-shares a 3-to-8 decoder
// among eight requesters. A grant drives the decoder enable plus the
// grantee index and lasts until the holder releases it, withdraws its
// request, or the hold limit is reached. Every grant is followed by a
// dead cycle (GAP) and one arbitration cycle (IDLE). That keeps two
// decoder lines from ever being high in back-to-back cycles.

module dec_rr_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       dec_en,
    output logic [2:0] dec_x,
    output logic       timeout
);

    // Last legal counter value. A grant that reaches it ends on that edge.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Pick the first requester at or after 'base', wrapping modulo 8.
    // Returns 'base' when nothing is requested. Callers only use the
    // result when req is non-zero.
    function automatic logic [2:0] rr_pick(input logic [7:0] req_v,
                                           input logic [2:0] base);
        logic [2:0] idx_s;
        logic [2:0] win_s;
        logic       found_s;
        win_s   = base;
        found_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx_s = base + 3'(i);
            if (!found_s && req_v[idx_s]) begin
                win_s   = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        return win_s;
    endfunction

    state_t     state_r, state_nxt_s;
    logic [2:0] ptr_r, ptr_nxt_s;
    logic [7:0] cnt_r, cnt_nxt_s;
    logic [2:0] dec_x_r, dec_x_nxt_s;
    logic       dec_en_r, dec_en_nxt_s;
    logic       timeout_r, timeout_nxt_s;
    logic       release_s;
    logic       limit_s;
    logic [2:0] winner_s;

    assign winner_s  = rr_pick(req, ptr_r);
    // Release covers both an explicit done and a withdrawn request.
    // It outranks the hold limit when both are true on the same edge.
    assign release_s = done | ~req[dec_x_r];
    assign limit_s   = (cnt_r == HOLD_LAST);

    // Next-state, pointer, counter and output-register inputs
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        dec_x_nxt_s   = dec_x_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != 8'd0) begin
                    dec_x_nxt_s = winner_s;
                    cnt_nxt_s   = 8'd0;
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s || limit_s) begin
                    state_nxt_s   = ST_GAP;
                    ptr_nxt_s     = dec_x_r + 3'd1;
                    timeout_nxt_s = limit_s & ~release_s;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_GAP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        dec_en_nxt_s = (state_nxt_s == ST_GRANT);
    end

    // State, pointer, counter and registered outputs. The asynchronous
    // reset drops dec_en at once, even in the middle of a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 3'd0;
            cnt_r     <= 8'd0;
            dec_x_r   <= 3'd0;
            dec_en_r  <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            dec_x_r   <= dec_x_nxt_s;
            dec_en_r  <= dec_en_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign dec_en  = dec_en_r;
    assign dec_x   = dec_x_r;
    assign timeout = timeout_r;

    dec_rr_arbiter_chk #(
        .HOLD_LAST (HOLD_LAST)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .dec_en  (dec_en_r),
        .dec_x   (dec_x_r),
        .timeout (timeout_r),
        .cnt     (cnt_r)
    );

endmodule

// Protocol checker for dec_rr_arbiter outputs.
module dec_rr_arbiter_chk #(
    parameter logic [7:0] HOLD_LAST = 8'd14
) (
    input logic       clk,
    input logic       rst,
    input logic       dec_en,
    input logic [2:0] dec_x,
    input logic       timeout,
    input logic [7:0] cnt
);

    // timeout only appears in GAP, so it never overlaps a grant.
    a_no_to_in_grant: assert property (@(posedge clk) disable iff (rst)
        !(dec_en && timeout));

    // The grantee index stays fixed while the grant is active.
    a_x_stable: assert property (@(posedge clk) disable iff (rst)
        dec_en |=> (!dec_en || $stable(dec_x)));

    // A grant ending is followed by at least two low cycles.
    a_two_gap: assert property (@(posedge clk) disable iff (rst)
        (dec_en ##1 !dec_en) |=> !dec_en);

    // The hold counter never passes the last legal value.
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt <= HOLD_LAST);

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Bench for dec_rr_arbiter with MAX_HOLD=4. Each vector gives one cycle
// of inputs and the outputs expected after the next rising edge.
// Expected values are queued when the inputs are driven and popped when
// the outputs are sampled.

module tb_dec_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       dec_en;
    logic [2:0] dec_x;
    logic       timeout;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       en;
        logic [2:0] x;
        logic       to;
        string      name;
    } vec_t;

    typedef struct {
        logic       en;
        logic [2:0] x;
        logic       to;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks;
    int   n_pass;

    dec_rr_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .dec_en  (dec_en),
        .dec_x   (dec_x),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [7:0] r, input logic d, input logic en,
                       input logic [2:0] x, input logic to, input string nm);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.en   = en;
        v.x    = x;
        v.to   = to;
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check_out(input exp_t e);
        n_checks++;
        if ({dec_en, dec_x, timeout} !== {e.en, e.x, e.to}) begin
            $display("FAIL %s: got en=%0b x=%0d to=%0b, expected en=%0b x=%0d to=%0b",
                     e.name, dec_en, dec_x, timeout, e.en, e.x, e.to);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        e.en   = v.en;
        e.x    = v.x;
        e.to   = v.to;
        e.name = v.name;
        sb_q.push_back(e);
        req  = v.req;
        done = v.done;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: got empty queue, expected one entry");
        end else begin
            check_out(sb_q.pop_front());
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        n_checks = 0;
        n_pass   = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;

        // Reset held for three edges with every requester asking.
        for (int i = 0; i < 3; i++) begin
            add(8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, "reset");
        end
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end
        rst = 1'b0;
        vecs.delete();

        // Rotation: done in the first cycle of every grant.
        add(8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, "rot first grant");
        for (int k = 0; k < 8; k++) begin
            add(8'hFF, 1'b1, 1'b0, 3'(k), 1'b0, "rot release");
            add(8'hFF, 1'b0, 1'b0, 3'(k), 1'b0, "rot idle cycle");
            add(8'hFF, 1'b0, 1'b1, 3'(k + 1), 1'b0, "rot next grant");
        end
        add(8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, "rot end");
        add(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "idle after rot");
        add(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "idle no req");
        // Single request 3, done in the third grant cycle. Afterwards ptr=4.
        add(8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "single grant");
        add(8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "single hold1");
        add(8'h08, 1'b0, 1'b1, 3'd3, 1'b0, "single hold2");
        add(8'h08, 1'b1, 1'b0, 3'd3, 1'b0, "single done");
        add(8'h08, 1'b0, 1'b0, 3'd3, 1'b0, "single idle");
        // Wrap from ptr=4 with req 0100_0011: order 6, 0, 1.
        add(8'h43, 1'b0, 1'b1, 3'd6, 1'b0, "wrap grant 6");
        add(8'h43, 1'b1, 1'b0, 3'd6, 1'b0, "wrap done 6");
        add(8'h43, 1'b0, 1'b0, 3'd6, 1'b0, "wrap idle");
        add(8'h43, 1'b0, 1'b1, 3'd0, 1'b0, "wrap grant 0");
        add(8'h42, 1'b0, 1'b0, 3'd0, 1'b0, "withdraw 0");
        add(8'h43, 1'b0, 1'b0, 3'd0, 1'b0, "withdraw idle");
        add(8'h43, 1'b0, 1'b1, 3'd1, 1'b0, "wrap grant 1");
        add(8'h43, 1'b1, 1'b0, 3'd1, 1'b0, "wrap done 1");
        add(8'h00, 1'b0, 1'b0, 3'd1, 1'b0, "wrap idle 2");
        // Timeout: requester 5 held, no done.
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to grant");
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to hold1");
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to hold2");
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to hold3");
        add(8'h20, 1'b0, 1'b0, 3'd5, 1'b1, "to pulse");
        add(8'h20, 1'b0, 1'b0, 3'd5, 1'b0, "to cleared");
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "to regrant");
        // done on the same edge as the hold limit counts as a release.
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "lim hold1");
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "lim hold2");
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "lim hold3");
        add(8'h20, 1'b1, 1'b0, 3'd5, 1'b0, "done at limit");
        // done outside a grant is ignored and not latched.
        add(8'h00, 1'b1, 1'b0, 3'd5, 1'b0, "done in gap");
        add(8'h00, 1'b1, 1'b0, 3'd5, 1'b0, "done in idle");
        add(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, "grant 2");
        add(8'h04, 1'b0, 1'b1, 3'd2, 1'b0, "done not latched");
        add(8'h00, 1'b0, 1'b0, 3'd2, 1'b0, "withdraw 2");
        add(8'h00, 1'b0, 1'b0, 3'd2, 1'b0, "idle again");
        // ptr is now 3, so requester 5 wins next.
        add(8'h20, 1'b0, 1'b1, 3'd5, 1'b0, "pre-reset grant");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset in the middle of grant 5: outputs clear without a clock edge.
        rst = 1'b1;
        #1;
        e.en   = 1'b0;
        e.x    = 3'd0;
        e.to   = 1'b0;
        e.name = "async reset";
        check_out(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // ptr must be back at 0, so requester 0 beats requester 5.
        v.req  = 8'h21;
        v.done = 1'b0;
        v.en   = 1'b1;
        v.x    = 3'd0;
        v.to   = 1'b0;
        v.name = "post reset grant";
        apply(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
